// File: rtl/vector_mem_sequencer.sv
// Purpose : steps one strided vector load/store over vl elements, two per beat, onto a
//           two-lane address scheduler; generates lane addresses/store data, tracks
//           per-lane arrival, raises load writeback strobes and holds faults until acked.
// Latency : start -> first request 1 cycle; best case ceil(vl/2) beats + 1 done cycle.
// Backpressure: a beat is held (addresses/data stable) until both pending lanes arrive;
//           sched_busy is informational and never stalls the sequencer.
// Ports   : CLK/RST (sync, active-high); start/is_load/is_store/base_addr/stride/vl/sew_in
//           instruction in; vs_idx*/vs_data* register-file read; addr*/storedata*/load/
//           store/sew/returnex to scheduler; arrived*/exception/sched_busy from scheduler;
//           wb_valid*/wb_idx* load writeback; busy/done/exc_out/exc_idx status; exc_ack in.
module vector_mem_sequencer #(
   parameter int MAX_VL = 32,
   parameter int VL_W   = $clog2(MAX_VL) + 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            start,
   input  logic            is_load,
   input  logic            is_store,
   input  logic [31:0]     base_addr,
   input  logic [31:0]     stride,
   input  logic [VL_W-1:0] vl,
   input  logic [1:0]      sew_in,
   output logic [VL_W-1:0] vs_idx0,
   output logic [VL_W-1:0] vs_idx1,
   input  logic [31:0]     vs_data0,
   input  logic [31:0]     vs_data1,
   output logic [31:0]     addr0,
   output logic [31:0]     addr1,
   output logic [31:0]     storedata0,
   output logic [31:0]     storedata1,
   output logic            load,
   output logic            store,
   output logic            returnex,
   output logic [1:0]      sew,
   input  logic            arrived0,
   input  logic            arrived1,
   input  logic            exception,
   input  logic            sched_busy,
   output logic            wb_valid0,
   output logic            wb_valid1,
   output logic [VL_W-1:0] wb_idx0,
   output logic [VL_W-1:0] wb_idx1,
   output logic            busy,
   output logic            done,
   output logic            exc_out,
   output logic [VL_W-1:0] exc_idx,
   input  logic            exc_ack
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BEAT  = 2'd1,
      S_DONE  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [VL_W-1:0] idx_q, idx_d;
   logic [31:0]     a0_q, a0_d;
   logic [31:0]     a1_q, a1_d;
   logic [31:0]     stride_q, stride_d;
   logic            p0_q, p0_d;
   logic            p1_q, p1_d;
   logic [VL_W-1:0] vl_q, vl_d;
   logic [1:0]      sew_q, sew_d;
   logic            ld_q, ld_d;
   logic [VL_W-1:0] exc_idx_q, exc_idx_d;

   // Index arithmetic one bit wider than vl so the end-of-vector compares never wrap.
   logic [VL_W:0]   idx_p1, idx_p2, idx_p3, vl_ext;
   logic            lane1_ok;
   logic            in_beat;
   logic            op_legal;
   logic            p0_nxt, p1_nxt;
   logic [31:0]     stride2;

   assign idx_p1   = {1'b0, idx_q} + (VL_W+1)'(1);
   assign idx_p2   = {1'b0, idx_q} + (VL_W+1)'(2);
   assign idx_p3   = {1'b0, idx_q} + (VL_W+1)'(3);
   assign vl_ext   = {1'b0, vl_q};
   assign lane1_ok = (idx_p1 < vl_ext);
   assign in_beat  = (state_q == S_BEAT);
   assign op_legal = (is_load ^ is_store) && (sew_in != 2'b11);
   assign stride2  = {stride_q[30:0], 1'b0};

   // Moore decodes: everything is forced to zero outside BEAT so IDLE (and reset) shows
   // an all-zero interface. An invalid lane 1 mirrors lane 0 so the scheduler sees a
   // harmless duplicate rather than an out-of-range address.
   assign addr0      = in_beat ? a0_q : 32'd0;
   assign addr1      = in_beat ? (lane1_ok ? a1_q : a0_q) : 32'd0;
   assign storedata0 = in_beat ? vs_data0 : 32'd0;
   assign storedata1 = in_beat ? (lane1_ok ? vs_data1 : vs_data0) : 32'd0;
   assign vs_idx0    = in_beat ? idx_q : '0;
   assign vs_idx1    = in_beat ? idx_p1[VL_W-1:0] : '0;
   assign load       = in_beat & ld_q;
   assign store      = in_beat & ~ld_q;
   assign sew        = sew_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign exc_out    = (state_q == S_FAULT);
   assign exc_idx    = exc_idx_q;
   assign returnex   = (state_q == S_FAULT) & exc_ack;
   assign wb_idx0    = wb_valid0 ? idx_q : '0;
   assign wb_idx1    = wb_valid1 ? idx_p1[VL_W-1:0] : '0;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      a0_d      = a0_q;
      a1_d      = a1_q;
      stride_d  = stride_q;
      p0_d      = p0_q;
      p1_d      = p1_q;
      vl_d      = vl_q;
      sew_d     = sew_q;
      ld_d      = ld_q;
      exc_idx_d = exc_idx_q;
      wb_valid0 = 1'b0;
      wb_valid1 = 1'b0;
      p0_nxt    = p0_q;
      p1_nxt    = p1_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (!op_legal) begin
                  exc_idx_d = '0;
                  state_d   = S_FAULT;
               end else if (vl == '0) begin
                  sew_d   = sew_in;
                  ld_d    = is_load;
                  state_d = S_DONE;
               end else begin
                  vl_d     = vl;
                  sew_d    = sew_in;
                  ld_d     = is_load;
                  stride_d = stride;
                  idx_d    = '0;
                  a0_d     = base_addr;
                  a1_d     = base_addr + stride;
                  p0_d     = 1'b1;
                  p1_d     = (vl > VL_W'(1));
                  state_d  = S_BEAT;
               end
            end
         end

         S_BEAT: begin
            if (exception) begin
               // Fault wins over same-cycle arrivals: they are dropped and the pending
               // bits are left as they were, so the oldest outstanding lane is reported.
               exc_idx_d = p0_q ? idx_q : idx_p1[VL_W-1:0];
               state_d   = S_FAULT;
            end else begin
               wb_valid0 = ld_q & arrived0 & p0_q;
               wb_valid1 = ld_q & arrived1 & p1_q;
               p0_nxt    = p0_q & ~arrived0;
               p1_nxt    = p1_q & ~arrived1;
               p0_d      = p0_nxt;
               p1_d      = p1_nxt;
               if (!p0_nxt && !p1_nxt) begin
                  idx_d = idx_p2[VL_W-1:0];
                  a0_d  = a0_q + stride2;
                  a1_d  = a1_q + stride2;
                  if (idx_p2 >= vl_ext) begin
                     state_d = S_DONE;
                  end else begin
                     p0_d = 1'b1;
                     p1_d = (idx_p3 < vl_ext);
                  end
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         S_FAULT: begin
            if (exc_ack) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         a0_q      <= '0;
         a1_q      <= '0;
         stride_q  <= '0;
         p0_q      <= 1'b0;
         p1_q      <= 1'b0;
         vl_q      <= '0;
         sew_q     <= '0;
         ld_q      <= 1'b0;
         exc_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         a0_q      <= a0_d;
         a1_q      <= a1_d;
         stride_q  <= stride_d;
         p0_q      <= p0_d;
         p1_q      <= p1_d;
         vl_q      <= vl_d;
         sew_q     <= sew_d;
         ld_q      <= ld_d;
         exc_idx_q <= exc_idx_d;
      end
   end

   // The scheduler's busy flag is carried for visibility only.
   logic unused_ok;
   assign unused_ok = sched_busy;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: acts as register file (vs_data derived from
// vs_idx) and as the scheduler (arrivals/exceptions driven per cycle); load writebacks are
// scoreboarded against expectations queued when the arrivals are driven.
module tb_vector_mem_sequencer;
   localparam int VL_W = 6;

   logic            CLK = 1'b0;
   logic            RST;
   logic            start, is_load, is_store;
   logic [31:0]     base_addr, stride;
   logic [VL_W-1:0] vl;
   logic [1:0]      sew_in;
   logic [VL_W-1:0] vs_idx0, vs_idx1;
   logic [31:0]     vs_data0, vs_data1;
   logic [31:0]     addr0, addr1, storedata0, storedata1;
   logic            load, store, returnex;
   logic [1:0]      sew;
   logic            arrived0, arrived1, exception, sched_busy;
   logic            wb_valid0, wb_valid1;
   logic [VL_W-1:0] wb_idx0, wb_idx1;
   logic            busy, done, exc_out;
   logic [VL_W-1:0] exc_idx;
   logic            exc_ack;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic            v0;
      logic [VL_W-1:0] i0;
      logic            v1;
      logic [VL_W-1:0] i1;
   } wb_t;
   wb_t sb[$];

   always #5 CLK = ~CLK;

   // Register-file model: data encodes lane and element index.
   assign vs_data0 = 32'hA000_0000 | 32'(vs_idx0);
   assign vs_data1 = 32'hB000_0000 | 32'(vs_idx1);

   vector_mem_sequencer dut (
      .CLK(CLK), .RST(RST), .start(start), .is_load(is_load), .is_store(is_store),
      .base_addr(base_addr), .stride(stride), .vl(vl), .sew_in(sew_in),
      .vs_idx0(vs_idx0), .vs_idx1(vs_idx1), .vs_data0(vs_data0), .vs_data1(vs_data1),
      .addr0(addr0), .addr1(addr1), .storedata0(storedata0), .storedata1(storedata1),
      .load(load), .store(store), .returnex(returnex), .sew(sew),
      .arrived0(arrived0), .arrived1(arrived1), .exception(exception), .sched_busy(sched_busy),
      .wb_valid0(wb_valid0), .wb_valid1(wb_valid1), .wb_idx0(wb_idx0), .wb_idx1(wb_idx1),
      .busy(busy), .done(done), .exc_out(exc_out), .exc_idx(exc_idx), .exc_ack(exc_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Drive this cycle's scheduler inputs, queue the expected writeback, settle, compare.
   task automatic cyc(input string tag, input logic ar0, input logic ar1, input logic ex,
                      input logic ack, input logic ev0, input int ei0,
                      input logic ev1, input int ei1);
      wb_t e;
      arrived0  = ar0;
      arrived1  = ar1;
      exception = ex;
      exc_ack   = ack;
      sb.push_back('{ev0, VL_W'(ei0), ev1, VL_W'(ei1)});
      #1;
      e = sb.pop_front();
      chk({tag, "_wbv0"}, 32'(wb_valid0), 32'(e.v0));
      chk({tag, "_wbv1"}, 32'(wb_valid1), 32'(e.v1));
      if (e.v0) chk({tag, "_wbi0"}, 32'(wb_idx0), 32'(e.i0));
      if (e.v1) chk({tag, "_wbi1"}, 32'(wb_idx1), 32'(e.i1));
   endtask

   task automatic start_op(input logic ld, input logic st, input logic [31:0] b,
                           input logic [31:0] s, input int n, input logic [1:0] w);
      start = 1'b1; is_load = ld; is_store = st;
      base_addr = b; stride = s; vl = VL_W'(n); sew_in = w;
      tick();
      start = 1'b0;
   endtask

   initial begin
      RST = 1'b1; start = 0; is_load = 0; is_store = 0; base_addr = 0; stride = 0;
      vl = 0; sew_in = 0; arrived0 = 0; arrived1 = 0; exception = 0; sched_busy = 0;
      exc_ack = 0;
      tick(); tick();
      RST = 1'b0;
      sched_busy = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_load", 32'(load), 0);
      chk("rst_store", 32'(store), 0);
      chk("rst_addr1", addr1, 0);
      chk("rst_sd0", storedata0, 0);
      chk("rst_vsidx1", 32'(vs_idx1), 0);
      chk("rst_excidx", 32'(exc_idx), 0);
      chk("rst_excout", 32'(exc_out), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_wbi1", 32'(wb_idx1), 0);

      // Load vl=4, immediate arrivals.
      start_op(1, 0, 32'h1000, 32'd4, 4, 2'b10);
      cyc("t1c1", 1, 1, 0, 0, 1, 0, 1, 1);
      chk("t1c1_a0", addr0, 32'h1000);
      chk("t1c1_a1", addr1, 32'h1004);
      chk("t1c1_ld", 32'(load), 1);
      chk("t1c1_st", 32'(store), 0);
      chk("t1c1_sew", 32'(sew), 2);
      chk("t1c1_busy", 32'(busy), 1);
      tick();
      cyc("t1c2", 1, 1, 0, 0, 1, 2, 1, 3);
      chk("t1c2_a0", addr0, 32'h1008);
      chk("t1c2_a1", addr1, 32'h100C);
      tick();
      cyc("t1c3", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t1c3_done", 32'(done), 1);
      chk("t1c3_ld", 32'(load), 0);
      tick();
      cyc("t1c4", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t1c4_busy", 32'(busy), 0);
      chk("t1c4_done", 32'(done), 0);

      // Store vl=3, odd tail: lane 1 mirrors lane 0.
      start_op(0, 1, 32'h200, 32'd8, 3, 2'b00);
      cyc("t2c1", 1, 1, 0, 0, 0, 0, 0, 0);
      chk("t2c1_st", 32'(store), 1);
      chk("t2c1_a1", addr1, 32'h208);
      chk("t2c1_sd0", storedata0, 32'hA000_0000);
      chk("t2c1_sd1", storedata1, 32'hB000_0001);
      tick();
      cyc("t2c2", 1, 0, 0, 0, 0, 0, 0, 0);
      chk("t2c2_a0", addr0, 32'h210);
      chk("t2c2_a1", addr1, 32'h210);
      chk("t2c2_sd0", storedata0, 32'hA000_0002);
      chk("t2c2_sd1", storedata1, 32'hA000_0002);
      tick();
      cyc("t2c3", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t2c3_done", 32'(done), 1);
      tick();

      // Staggered arrivals; repeated arrived0 is ignored.
      start_op(1, 0, 32'h1000, 32'd4, 4, 2'b10);
      cyc("t3c1", 1, 0, 0, 0, 1, 0, 0, 0);
      chk("t3c1_a0", addr0, 32'h1000);
      tick();
      cyc("t3c2", 1, 0, 0, 0, 0, 0, 0, 0);
      chk("t3c2_a0", addr0, 32'h1000);
      chk("t3c2_a1", addr1, 32'h1004);
      tick();
      cyc("t3c3", 0, 1, 0, 0, 0, 0, 1, 1);
      chk("t3c3_a1", addr1, 32'h1004);
      tick();
      cyc("t3c4", 1, 1, 0, 0, 1, 2, 1, 3);
      chk("t3c4_a0", addr0, 32'h1008);
      tick();
      cyc("t3c5", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t3c5_done", 32'(done), 1);
      tick();

      // Exception on beat 2 after lane 0 arrived.
      start_op(1, 0, 32'h1000, 32'd4, 4, 2'b10);
      cyc("t4c1", 1, 1, 0, 0, 1, 0, 1, 1);
      tick();
      cyc("t4c2", 1, 0, 0, 0, 1, 2, 0, 0);
      tick();
      cyc("t4c3", 0, 1, 1, 0, 0, 0, 0, 0);
      chk("t4c3_a0", addr0, 32'h1008);
      tick();
      cyc("t4c4", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t4c4_excout", 32'(exc_out), 1);
      chk("t4c4_excidx", 32'(exc_idx), 3);
      chk("t4c4_ld", 32'(load), 0);
      chk("t4c4_rex", 32'(returnex), 0);
      tick();
      cyc("t4c5", 0, 0, 0, 1, 0, 0, 0, 0);
      chk("t4c5_rex", 32'(returnex), 1);
      tick();
      cyc("t4c6", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t4c6_busy", 32'(busy), 0);
      chk("t4c6_rex", 32'(returnex), 0);
      chk("t4c6_excout", 32'(exc_out), 0);

      // Exception together with arrived0: arrival discarded.
      start_op(1, 0, 32'h1000, 32'd4, 4, 2'b10);
      cyc("t5c1", 1, 1, 0, 0, 1, 0, 1, 1);
      tick();
      cyc("t5c2", 1, 0, 1, 0, 0, 0, 0, 0);
      tick();
      cyc("t5c3", 0, 0, 0, 1, 0, 0, 0, 0);
      chk("t5c3_excidx", 32'(exc_idx), 2);
      tick();

      // Both op bits set: illegal.
      start_op(1, 1, 32'h1000, 32'd4, 4, 2'b10);
      cyc("t6c1", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6c1_excout", 32'(exc_out), 1);
      chk("t6c1_excidx", 32'(exc_idx), 0);
      chk("t6c1_ld", 32'(load), 0);
      tick();
      cyc("t6c2", 0, 0, 0, 1, 0, 0, 0, 0);
      tick();

      // sew_in = 11: illegal.
      start_op(1, 0, 32'h1000, 32'd4, 4, 2'b11);
      cyc("t7c1", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t7c1_excout", 32'(exc_out), 1);
      tick();
      cyc("t7c2", 0, 0, 0, 1, 0, 0, 0, 0);
      tick();

      // vl = 0: straight to done.
      start_op(1, 0, 32'h1000, 32'd4, 0, 2'b10);
      cyc("t8c1", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t8c1_done", 32'(done), 1);
      chk("t8c1_ld", 32'(load), 0);
      tick();
      cyc("t8c2", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t8c2_busy", 32'(busy), 0);

      // Negative stride.
      start_op(1, 0, 32'h10, 32'hFFFF_FFFC, 4, 2'b10);
      cyc("t9c1", 1, 1, 0, 0, 1, 0, 1, 1);
      chk("t9c1_a0", addr0, 32'h10);
      chk("t9c1_a1", addr1, 32'h0C);
      tick();
      cyc("t9c2", 1, 1, 0, 0, 1, 2, 1, 3);
      chk("t9c2_a0", addr0, 32'h08);
      chk("t9c2_a1", addr1, 32'h04);
      tick();
      tick();

      // Reset during beat 2.
      start_op(1, 0, 32'h300, 32'd4, 4, 2'b10);
      cyc("t10c1", 1, 1, 0, 0, 1, 0, 1, 1);
      tick();
      RST = 1'b1;
      cyc("t10c2", 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      RST = 1'b0;
      cyc("t10c3", 1, 1, 0, 0, 0, 0, 0, 0);
      chk("t10c3_busy", 32'(busy), 0);
      chk("t10c3_ld", 32'(load), 0);
      chk("t10c3_a0", addr0, 0);
      chk("t10c3_sd1", storedata1, 0);
      chk("t10c3_sew", 32'(sew), 0);
      chk("t10c3_vsidx1", 32'(vs_idx1), 0);
      tick();
      cyc("t10c4", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t10c4_done", 32'(done), 0);

      // start during BEAT is ignored.
      start_op(1, 0, 32'h40, 32'd4, 2, 2'b10);
      start = 1'b1; base_addr = 32'h999; vl = VL_W'(8);
      cyc("t11c1", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t11c1_a0", addr0, 32'h40);
      tick();
      start = 1'b0;
      cyc("t11c2", 1, 1, 0, 0, 1, 0, 1, 1);
      chk("t11c2_a0", addr0, 32'h40);
      chk("t11c2_a1", addr1, 32'h44);
      tick();
      cyc("t11c3", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t11c3_done", 32'(done), 1);
      tick();
      cyc("t11c4", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t11c4_busy", 32'(busy), 0);

      chk("sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
